// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: sequences the core clock PLL from its reference clock.
// Pulses the PLL reset, waits for a synchronised and debounced lock, then
// releases the downstream system reset. Lock timeouts retry a bounded number
// of times before parking in FAULT; loss of lock while running re-sequences.
// Optional build macro: PLL_LOL_COUNT_EN adds a saturating loss-of-lock counter.
module pll_reset_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [2:0] state,
    output logic [7:0] lol_count
);

    localparam int PW = $clog2(RST_PULSE_CYCLES);
    localparam int SW = $clog2(LOCK_STABLE_CYCLES);
    localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES);

    // Terminal values: the transition fires on the edge the count would reach its target.
    localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);
    localparam logic [SW-1:0] STAB_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   pulse_q, pulse_d;
    logic [SW-1:0]   stab_q, stab_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [3:0]      retry_q, retry_d;
    logic            sync1_q, sync2_q;
    logic            lock_s;
    logic            lol_inc_s;
    logic            pll_rst_q, pll_rst_d;
    logic            sys_rst_n_q, sys_rst_n_d;
    logic            ready_q, ready_d;
    logic            fault_q, fault_d;

    // Two-flop synchroniser bringing the asynchronous lock indication into refclk.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pll_locked;
            sync2_q <= sync1_q;
        end
    end

    assign lock_s = sync2_q;

    // Next-state and counter logic; restart overrides every other event.
    always_comb begin
        state_d   = state_q;
        pulse_d   = pulse_q;
        stab_d    = stab_q;
        tmo_d     = tmo_q;
        retry_d   = retry_q;
        lol_inc_s = 1'b0;
        if (restart) begin
            state_d = ST_HOLD;
            pulse_d = {PW{1'b0}};
            retry_d = 4'd0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    tmo_d = {TW{1'b0}};
                    if (pulse_q == PULSE_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        pulse_d = {PW{1'b0}};
                    end else begin
                        pulse_d = pulse_q + PW'(1);
                    end
                end
                ST_WAIT_LOCK, ST_STABLE: begin
                    if (tmo_q == TMO_LAST) begin
                        // Timeout wins over any lock progress on this edge.
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + 4'd1;
                            state_d = ST_HOLD;
                        end else begin
                            state_d = ST_FAULT;
                        end
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                        if (state_q == ST_WAIT_LOCK) begin
                            if (lock_s) begin
                                state_d = ST_STABLE;
                                stab_d  = {SW{1'b0}};
                            end else begin
                                state_d = ST_WAIT_LOCK;
                            end
                        end else if (!lock_s) begin
                            // Lock dropped while debouncing; keep the attempt timer running.
                            state_d = ST_WAIT_LOCK;
                        end else if (stab_q == STAB_LAST) begin
                            state_d = ST_RUN;
                            retry_d = 4'd0;
                        end else begin
                            stab_d = stab_q + SW'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d   = ST_HOLD;
                        pulse_d   = {PW{1'b0}};
                        lol_inc_s = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_HOLD;
                    pulse_d = {PW{1'b0}};
                end
            endcase
        end
    end

    // Output values for the state being entered, so outputs switch on the transition edge.
    always_comb begin
        pll_rst_d   = 1'b1;
        sys_rst_n_d = 1'b0;
        ready_d     = 1'b0;
        fault_d     = 1'b0;
        case (state_d)
            ST_WAIT_LOCK, ST_STABLE: begin
                pll_rst_d = 1'b0;
            end
            ST_RUN: begin
                pll_rst_d   = 1'b0;
                sys_rst_n_d = 1'b1;
                ready_d     = 1'b1;
            end
            ST_FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                pll_rst_d = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HOLD;
            pulse_q     <= {PW{1'b0}};
            stab_q      <= {SW{1'b0}};
            tmo_q       <= {TW{1'b0}};
            retry_q     <= 4'd0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pulse_q     <= pulse_d;
            stab_q      <= stab_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

`ifdef PLL_LOL_COUNT_EN
    logic [7:0] lol_q;

    // Saturating loss-of-lock event counter; only rst_n clears it.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lol_q <= 8'd0;
        end else if (lol_inc_s && (lol_q != 8'hFF)) begin
            lol_q <= lol_q + 8'd1;
        end else begin
            lol_q <= lol_q;
        end
    end

    assign lol_count = lol_q;
`else
    logic lol_unused_s;
    assign lol_unused_s = lol_inc_s;
    assign lol_count    = 8'd0;
`endif

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;
    assign state     = state_q;

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Controls the reset and lock sequencing of the core clock PLL (50 MHz refclk in, 35 MHz outclk_0 out). Pulses the PLL reset, waits for a qualified, debounced lock, then releases the downstream system reset. On lock timeout it retries a bounded number of times, then parks in FAULT. On loss of lock it re-sequences. Runs entirely in the refclk domain; consumers in the outclk_0 domain re-synchronise sys_rst_n locally.

Parameters:
RST_PULSE_CYCLES, 16, refclk cycles pll_rst is held high per attempt (>=2)
LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock-high cycles required before release (>=2)
LOCK_TIMEOUT_CYCLES, 50000, max cycles from HOLD exit to RUN entry per attempt
MAX_RETRIES, 3, re-attempts after the first timeout before FAULT (1..15)

Ports:
refclk  input  1  sequencer clock (PLL reference clock)
rst_n  input  1  asynchronous active-low reset
pll_locked  input  1  PLL locked, asynchronous to refclk
restart  input  1  synchronous single-cycle request to re-sequence the PLL
pll_rst  output  1  active-high reset to the PLL rst input
sys_rst_n  output  1  active-low system reset, deasserted only in RUN
ready  output  1  high only in RUN
fault  output  1  high only in FAULT
retry_cnt  output  4  timeouts taken in the current sequence
state  output  3  current state encoding, for debug
lol_count  output  8  loss-of-lock event count (see Optional Feature)

Behaviour:
- rst_n low (async): state=HOLD, pll_rst=1, sys_rst_n=0, ready=0, fault=0, retry_cnt=0, lol_count=0, all counters 0, synchroniser flops 0.
- pll_locked passes through a 2-flop synchroniser (lock_s). All decisions use lock_s, which adds 2 cycles of latency.
- All outputs are registered and change on the edge that performs the transition.
- State encodings: HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4. Other values recover to HOLD.
- HOLD: pll_rst=1. Count RST_PULSE_CYCLES cycles, then go to WAIT_LOCK with pll_rst=0 and the timeout counter cleared.
- WAIT_LOCK: lock_s=1 -> STABLE, with the stable counter cleared.
- STABLE:
  - Stable counter increments while lock_s=1.
  - lock_s=0 -> back to WAIT_LOCK. The timeout counter is NOT cleared.
  - Count reaches LOCK_STABLE_CYCLES -> RUN. sys_rst_n=1, ready=1, retry_cnt cleared.
- Timeout: the counter runs in WAIT_LOCK and STABLE. When it reaches LOCK_TIMEOUT_CYCLES:
  - if retry_cnt < MAX_RETRIES: retry_cnt++ and go to HOLD;
  - otherwise go to FAULT.
  - Timeout has priority over the STABLE->RUN transition in the same cycle.
- RUN: lock_s=0 -> HOLD (loss of lock). On that edge sys_rst_n=0, ready=0, pll_rst=1.
- FAULT: pll_rst=1, sys_rst_n=0, fault=1. Held until restart or rst_n.
- restart=1 in any state -> HOLD with retry_cnt=0. restart has priority over every other event that cycle. restart in HOLD restarts the pulse count.
- pll_rst=0 only in WAIT_LOCK, STABLE and RUN.
- sys_rst_n=1 only in RUN.

Optional Feature:
PLL_LOL_COUNT_EN:
- Defined: lol_count increments on each RUN->HOLD loss-of-lock transition and saturates at 255. Cleared only by rst_n; restart does not clear it.
- Undefined: no counter flops; lol_count is tied to 0.

Test Plan:
Bench parameters: RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
1. Release rst_n; raise pll_locked 5 cycles after pll_rst falls -> pll_rst high for exactly 4 cycles; sys_rst_n and ready rise 2+8 cycles after pll_locked rises; retry_cnt=0.
2. Glitch pll_locked low for 3 cycles mid-STABLE -> state returns to WAIT_LOCK; RUN is reached only after 8 further consecutive high cycles, provided this is within 32 cycles of HOLD exit.
3. Hold pll_locked=0 -> three attempts (retry_cnt 0,1,2), each with a 4-cycle pll_rst pulse; after the third 32-cycle timeout, fault=1, state=4, pll_rst=1; then pulse restart -> state=0, retry_cnt=0, fault=0.
4. In RUN, drop pll_locked for 1 cycle -> 2 cycles later sys_rst_n=0, pll_rst=1, state=0; with PLL_LOL_COUNT_EN defined lol_count=1, otherwise 0; re-lock returns to RUN.
5. Assert rst_n low mid-STABLE, asynchronously between edges -> outputs take reset values immediately, with no clock edge required.
6. Assert restart in the same cycle as the STABLE->RUN completion -> state=0 (HOLD), sys_rst_n stays 0.
